// File: rtl/perif_bus_arbiter.sv
// Round-robin arbiter for two masters sharing the peripheral register bus.
// Each access runs SETUP -> STROBE -> DONE, with ack and read data returned to the winner.
module perif_bus_arbiter #(
  parameter int ADW  = 2,
  parameter int NDEV = 4,
  parameter int DW   = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               m0_req,
  input  logic               m0_we,
  input  logic [ADW-1:0]     m0_dev,
  input  logic [1:0]         m0_reg,
  input  logic [DW-1:0]      m0_wdata,
  output logic               m0_ack,
  output logic [DW-1:0]      m0_rdata,
  input  logic               m1_req,
  input  logic               m1_we,
  input  logic [ADW-1:0]     m1_dev,
  input  logic [1:0]         m1_reg,
  input  logic [DW-1:0]      m1_wdata,
  output logic               m1_ack,
  output logic [DW-1:0]      m1_rdata,
  output logic [NDEV-1:0]    dev_cs,
  output logic               dev_we,
  output logic [1:0]         dev_reg_sel,
  output logic [DW-1:0]      dev_wdata,
  input  logic [NDEV*DW-1:0] dev_rdata,
  output logic               busy
);

  typedef enum logic [1:0] {IDLE, SETUP, STROBE, DONE} state_t;

  state_t           state_reg, state_next;
  logic             last_grant_reg;
  logic             start_next;
  logic             pick_next;
  logic             cmd_we_reg;
  logic [ADW-1:0]   cmd_dev_reg;
  logic [1:0]       cmd_reg_reg;
  logic [DW-1:0]    cmd_wdata_reg;
  logic [DW-1:0]    m0_rdata_reg, m1_rdata_reg;
  logic             cs_active;
  logic [DW-1:0]    rd_slice;
  logic [DW-1:0]    slice_arr [2**ADW];

  // Every index the command register can hold maps to a slice; unpopulated ones read as zero.
  genvar gi;
  generate
    for (gi = 0; gi < 2**ADW; gi++) begin : g_slice
      if (gi < NDEV) begin : g_dev
        assign slice_arr[gi] = dev_rdata[gi*DW +: DW];
      end else begin : g_none
        assign slice_arr[gi] = '0;
      end
    end
  endgenerate

  assign rd_slice = slice_arr[cmd_dev_reg];

  // State register plus the command and read-data registers it owns.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= IDLE;
      last_grant_reg <= 1'b1;
      cmd_we_reg     <= 1'b0;
      cmd_dev_reg    <= '0;
      cmd_reg_reg    <= '0;
      cmd_wdata_reg  <= '0;
      m0_rdata_reg   <= '0;
      m1_rdata_reg   <= '0;
    end else begin
      state_reg <= state_next;
      if (start_next) begin
        last_grant_reg <= pick_next;
        cmd_we_reg     <= pick_next ? m1_we    : m0_we;
        cmd_dev_reg    <= pick_next ? m1_dev   : m0_dev;
        cmd_reg_reg    <= pick_next ? m1_reg   : m0_reg;
        cmd_wdata_reg  <= pick_next ? m1_wdata : m0_wdata;
      end
      if (state_reg == STROBE && !cmd_we_reg) begin
        if (last_grant_reg)
          m1_rdata_reg <= rd_slice;
        else
          m0_rdata_reg <= rd_slice;
      end
    end
  end

  // Grant goes to the only requester, or to the one not served last time.
  always_comb begin
    state_next = state_reg;
    start_next = 1'b0;
    pick_next  = last_grant_reg;
    case (state_reg)
      IDLE: begin
        if (m0_req || m1_req) begin
          start_next = 1'b1;
          state_next = SETUP;
          pick_next  = (m0_req && m1_req) ? ~last_grant_reg : m1_req;
        end
      end
      SETUP:   state_next = STROBE;
      STROBE:  state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    cs_active = (state_reg == SETUP) || (state_reg == STROBE);
    dev_we    = (state_reg == STROBE) && cmd_we_reg;
    m0_ack    = (state_reg == DONE) && !last_grant_reg;
    m1_ack    = (state_reg == DONE) && last_grant_reg;
    busy      = (state_reg != IDLE);
  end

  generate
    for (gi = 0; gi < NDEV; gi++) begin : g_cs
      assign dev_cs[gi] = cs_active && (cmd_dev_reg == ADW'(gi));
    end
  endgenerate

  assign dev_reg_sel = cmd_reg_reg;
  assign dev_wdata   = cmd_wdata_reg;
  assign m0_rdata    = m0_rdata_reg;
  assign m1_rdata    = m1_rdata_reg;

endmodule
